// File: rtl/l2_cache_nway.sv
// l2_cache_nway: N-way set-associative, write-back, write-allocate L2 cache with tree
// pseudo-LRU replacement, per-byte write merge and saturating hit/miss counters.
module l2_cache_nway #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_ways   = 2,
  parameter int s_tag    = 32 - s_offset - s_index,
  parameter int s_mask   = 2**s_offset,
  parameter int s_line   = 8*s_mask
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       mem_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [s_mask-1:0] mem_byte_enable,
  input  logic [s_line-1:0] mem_wdata,
  output logic [s_line-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_addr,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  input  logic              hit_clear,
  input  logic              miss_clear
);
  localparam int num_sets = 2**s_index;
  localparam int num_ways = 2**s_ways;
  localparam int plru_w   = num_ways - 1;

  typedef enum logic [1:0] {
    CHECK_TAG  = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [s_ways-1:0]   victim_q, victim_d;
  logic                pending_q, pending_d;
  logic [31:0]         hit_count_q, hit_count_d;
  logic [31:0]         miss_count_q, miss_count_d;

  logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
  logic [s_tag-1:0]    tag_d   [num_sets][num_ways];
  logic [num_ways-1:0] valid_q [num_sets];
  logic [num_ways-1:0] valid_d [num_sets];
  logic [num_ways-1:0] dirty_q [num_sets];
  logic [num_ways-1:0] dirty_d [num_sets];
  logic [plru_w-1:0]   plru_q  [num_sets];
  logic [plru_w-1:0]   plru_d  [num_sets];
  logic [s_line-1:0]   data_q  [num_sets][num_ways];

  logic [s_tag-1:0]    req_tag_s;
  logic [s_index-1:0]  req_idx_s;
  logic [s_offset-1:0] offset_unused_s;
  logic                lookup_s;
  logic                hit_s;
  logic [s_ways-1:0]   hit_way_s;
  logic [s_ways-1:0]   inv_way_s;
  logic                inv_any_s;
  logic [s_ways-1:0]   victim_sel_s;
  logic                victim_dirty_s;
  logic                data_we_s;
  logic [s_ways-1:0]   data_way_s;
  logic [s_line-1:0]   data_line_s;
  logic                hit_inc_s;
  logic                miss_inc_s;

  function automatic logic [s_line-1:0] merge_line(input logic [s_line-1:0] old_line,
                                                   input logic [s_line-1:0] new_line,
                                                   input logic [s_mask-1:0] be);
    logic [s_line-1:0] r;
    for (int b = 0; b < s_mask; b++) begin
      r[8*b +: 8] = be[b] ? new_line[8*b +: 8] : old_line[8*b +: 8];
    end
    return r;
  endfunction

  // Each tree node bit names the half holding the replacement candidate.
  function automatic logic [s_ways-1:0] plru_victim(input logic [plru_w-1:0] cur);
    int          node;
    logic [31:0] leaf;
    node = 1;
    for (int l = 0; l < s_ways; l++) begin
      node = 2*node + (cur[node-1] ? 1 : 0);
    end
    leaf = 32'(node - num_ways);
    return leaf[s_ways-1:0];
  endfunction

  function automatic logic [plru_w-1:0] plru_touch(input logic [plru_w-1:0] cur,
                                                   input logic [s_ways-1:0] way);
    logic [plru_w-1:0] nxt;
    logic              dir;
    int                node;
    nxt  = cur;
    node = 1;
    for (int l = 0; l < s_ways; l++) begin
      dir         = way[s_ways-1-l];
      nxt[node-1] = ~dir;
      node        = 2*node + (dir ? 1 : 0);
    end
    return nxt;
  endfunction

  assign req_tag_s       = mem_addr[31 -: s_tag];
  assign req_idx_s       = mem_addr[s_offset +: s_index];
  assign offset_unused_s = mem_addr[s_offset-1:0];
  assign lookup_s        = (state_q == CHECK_TAG) && (mem_read || mem_write);
  assign hit_count       = hit_count_q;
  assign miss_count      = miss_count_q;

  // Descending scan so the lowest-index match / invalid way wins.
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    inv_way_s = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      hit_s     = hit_s | (valid_q[req_idx_s][w] && (tag_q[req_idx_s][w] == req_tag_s));
      hit_way_s = (valid_q[req_idx_s][w] && (tag_q[req_idx_s][w] == req_tag_s)) ?
                  w[s_ways-1:0] : hit_way_s;
      inv_way_s = valid_q[req_idx_s][w] ? inv_way_s : w[s_ways-1:0];
    end
    inv_any_s      = ~&valid_q[req_idx_s];
    victim_sel_s   = inv_any_s ? inv_way_s : plru_victim(plru_q[req_idx_s]);
    victim_dirty_s = valid_q[req_idx_s][victim_sel_s] & dirty_q[req_idx_s][victim_sel_s];
  end

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    case (state_q)
      CHECK_TAG: begin
        if (lookup_s && !hit_s) begin
          victim_d = victim_sel_s;
          state_d  = victim_dirty_s ? WRITE_BACK : ALLOCATE;
        end else begin
          state_d  = CHECK_TAG;
        end
      end
      WRITE_BACK: state_d = pmem_resp ? ALLOCATE : WRITE_BACK;
      ALLOCATE:   state_d = pmem_resp ? CHECK_TAG : ALLOCATE;
      default:    state_d = CHECK_TAG;
    endcase
  end

  always_comb begin
    mem_resp   = lookup_s && hit_s;
    mem_rdata  = data_q[req_idx_s][hit_way_s];
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = 32'h0000_0000;
    pmem_wdata = '0;
    case (state_q)
      WRITE_BACK: begin
        pmem_write = 1'b1;
        pmem_addr  = {tag_q[req_idx_s][victim_q], req_idx_s, {s_offset{1'b0}}};
        pmem_wdata = data_q[req_idx_s][victim_q];
      end
      ALLOCATE: begin
        pmem_read  = 1'b1;
        pmem_addr  = {mem_addr[31:s_offset], {s_offset{1'b0}}};
      end
      default: pmem_addr = 32'h0000_0000;
    endcase
  end

  // Metadata and data-array write port: hit update or fill completion.
  always_comb begin
    tag_d       = tag_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    plru_d      = plru_q;
    data_we_s   = 1'b0;
    data_way_s  = hit_way_s;
    data_line_s = merge_line(data_q[req_idx_s][hit_way_s], mem_wdata, mem_byte_enable);
    if (lookup_s && hit_s) begin
      plru_d[req_idx_s] = plru_touch(plru_q[req_idx_s], hit_way_s);
      if (mem_write) begin
        dirty_d[req_idx_s][hit_way_s] = 1'b1;
        data_we_s                     = 1'b1;
      end else begin
        data_we_s                     = 1'b0;
      end
    end else if ((state_q == ALLOCATE) && pmem_resp) begin
      tag_d[req_idx_s][victim_q]   = req_tag_s;
      valid_d[req_idx_s][victim_q] = 1'b1;
      dirty_d[req_idx_s][victim_q] = 1'b0;
      data_we_s                    = 1'b1;
      data_way_s                   = victim_q;
      data_line_s                  = pmem_rdata;
    end else begin
      data_we_s                    = 1'b0;
    end
  end

  // The pending flag keeps the post-fill hit from being counted a second time.
  always_comb begin
    hit_inc_s  = lookup_s && hit_s && !pending_q;
    miss_inc_s = lookup_s && !hit_s && !pending_q;
    if (hit_clear) begin
      hit_count_d = 32'h0000_0000;
    end else if (hit_inc_s && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end else begin
      hit_count_d = hit_count_q;
    end
    if (miss_clear) begin
      miss_count_d = 32'h0000_0000;
    end else if (miss_inc_s && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end else begin
      miss_count_d = miss_count_q;
    end
    if (mem_resp) begin
      pending_d = 1'b0;
    end else if (miss_inc_s) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= CHECK_TAG;
      victim_q     <= '0;
      pending_q    <= 1'b0;
      hit_count_q  <= 32'h0000_0000;
      miss_count_q <= 32'h0000_0000;
      for (int s = 0; s < num_sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      pending_q    <= pending_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      plru_q       <= plru_d;
      tag_q        <= tag_d;
    end
  end

  // Line storage is not cleared by reset; cleared valid bits mask stale contents.
  always_ff @(posedge clk) begin
    if (reset_n && data_we_s) begin
      data_q[req_idx_s][data_way_s] <= data_line_s;
    end
  end

endmodule

// File: tb/tb_l2_cache_nway.sv
// Directed self-checking bench for l2_cache_nway (default 4-way, 8 sets, 32-byte lines).
module tb_l2_cache_nway;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [31:0]  mem_addr = 32'h0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  mem_byte_enable = 32'h0;
  logic [255:0] mem_wdata = '0;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_addr;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
  logic         hit_clear = 1'b0;
  logic         miss_clear = 1'b0;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  l2_cache_nway dut (
    .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .hit_count(hit_count),
    .miss_count(miss_count), .hit_clear(hit_clear), .miss_clear(miss_clear)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pat(input logic [7:0] seed);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = seed + 8'(i);
    return r;
  endfunction

  task automatic check_counts(input string tag);
    check_val({tag, ".hit_count"}, hit_count, 32'(exp_hits));
    check_val({tag, ".miss_count"}, miss_count, 32'(exp_misses));
  endtask

  task automatic do_reset();
    reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    hit_clear = 1'b0; miss_clear = 1'b0;
    @(posedge clk); #1;
    check_val("rst.pmem_read", pmem_read, 1'b0);
    check_val("rst.pmem_write", pmem_write, 1'b0);
    check_val("rst.mem_resp", mem_resp, 1'b0);
    check_val("rst.pmem_addr", pmem_addr, 32'h0);
    exp_hits = 0; exp_misses = 0;
    check_counts("rst");
    @(negedge clk); reset_n = 1'b1;
  endtask

  // One request: hit completes the same cycle; a miss optionally writes back, then fills.
  task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] be, input logic [255:0] wd, input logic exp_hit,
                        input logic [255:0] fill, input logic exp_wb,
                        input logic [31:0] wb_addr, input logic [255:0] wb_data,
                        output logic [255:0] rd);
    @(negedge clk);
    mem_addr = addr; mem_byte_enable = be; mem_wdata = wd;
    mem_read = !wr; mem_write = wr;
    #1;
    if (exp_hit) begin
      check_val({tag, ".hit_resp"}, mem_resp, 1'b1);
      exp_hits++;
    end else begin
      check_val({tag, ".miss_resp"}, mem_resp, 1'b0);
      exp_misses++;
      @(posedge clk); #1;
      if (exp_wb) begin
        check_val({tag, ".wb_write"}, pmem_write, 1'b1);
        check_val({tag, ".wb_read"}, pmem_read, 1'b0);
        check_val({tag, ".wb_addr"}, pmem_addr, wb_addr);
        check_val({tag, ".wb_data"}, pmem_wdata, wb_data);
        pmem_resp = 1'b1;
        @(posedge clk);
        @(negedge clk); pmem_resp = 1'b0; #1;
      end
      check_val({tag, ".alloc_read"}, pmem_read, 1'b1);
      check_val({tag, ".alloc_write"}, pmem_write, 1'b0);
      check_val({tag, ".alloc_addr"}, pmem_addr, {addr[31:5], 5'b0});
      pmem_rdata = fill; pmem_resp = 1'b1;
      @(posedge clk);
      @(negedge clk); pmem_resp = 1'b0; #1;
      check_val({tag, ".strobe_drop"}, pmem_read, 1'b0);
      check_val({tag, ".fill_resp"}, mem_resp, 1'b1);
    end
    rd = mem_rdata;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic read_hit(input string tag, input logic [31:0] addr, input logic [255:0] exp);
    logic [255:0] rd;
    access(tag, 1'b0, addr, 32'h0, '0, 1'b1, '0, 1'b0, 32'h0, '0, rd);
    check_val({tag, ".data"}, rd, exp);
  endtask

  task automatic read_miss(input string tag, input logic [31:0] addr, input logic [255:0] fill);
    logic [255:0] rd;
    access(tag, 1'b0, addr, 32'h0, '0, 1'b0, fill, 1'b0, 32'h0, '0, rd);
    check_val({tag, ".data"}, rd, fill);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [255:0] rd;
    logic [255:0] wbd;
    logic [255:0] merged;

    // Test 1: cold miss then hit on 0x40
    do_reset();
    read_miss("t1.miss", 32'h0000_0040, pat(8'hA0));
    check_counts("t1.after_miss");
    read_hit("t1.hit", 32'h0000_0040, pat(8'hA0));
    check_counts("t1.after_hit");

    // Test 2: set 2 with tags 1..4; touch order 3,1,2 leaves the tree pointing at tag 4
    do_reset();
    for (int t = 1; t <= 4; t++)
      read_miss($sformatf("t2.fill%0d", t), (32'(t) << 8) | 32'h40, pat(8'(t * 16)));
    read_hit("t2.touch3", 32'h0000_0340, pat(8'h30));
    read_hit("t2.touch1", 32'h0000_0140, pat(8'h10));
    read_hit("t2.touch2", 32'h0000_0240, pat(8'h20));
    read_miss("t2.tag5", 32'h0000_0540, pat(8'h50));
    read_hit("t2.keep1", 32'h0000_0140, pat(8'h10));
    read_hit("t2.keep2", 32'h0000_0240, pat(8'h20));
    read_hit("t2.keep3", 32'h0000_0340, pat(8'h30));
    read_miss("t2.evicted4", 32'h0000_0440, pat(8'h44));
    check_counts("t2");

    // Test 3: partial write to clean line in set 5, then evict it
    read_miss("t3.fill1", 32'h0000_01A0, pat(8'h80));
    access("t3.write", 1'b1, 32'h0000_01A0, 32'h0000_000F, {32{8'hAA}}, 1'b1,
           '0, 1'b0, 32'h0, '0, rd);
    read_miss("t3.fill2", 32'h0000_02A0, pat(8'h82));
    read_miss("t3.fill3", 32'h0000_03A0, pat(8'h83));
    read_miss("t3.fill4", 32'h0000_04A0, pat(8'h84));
    wbd = pat(8'h80);
    wbd[31:0] = 32'hAAAA_AAAA;
    access("t3.evict", 1'b0, 32'h0000_05A0, 32'h0, '0, 1'b0, pat(8'h85),
           1'b1, 32'h0000_01A0, wbd, rd);
    check_val("t3.evict.data", rd, pat(8'h85));
    check_counts("t3");

    // Test 4: write miss to set 6 merges upper 16 bytes after fill, line becomes dirty
    access("t4.wmiss", 1'b1, 32'h0000_07C0, 32'hFFFF_0000, {32{8'h55}}, 1'b0,
           pat(8'hC0), 1'b0, 32'h0, '0, rd);
    check_counts("t4.after_wmiss");
    merged = pat(8'hC0);
    merged[255:128] = {16{8'h55}};
    read_hit("t4.readback", 32'h0000_07C0, merged);
    read_miss("t4.fill8", 32'h0000_08C0, pat(8'hC8));
    read_miss("t4.fill9", 32'h0000_09C0, pat(8'hC9));
    read_miss("t4.fillA", 32'h0000_0AC0, pat(8'hCA));
    access("t4.evict", 1'b0, 32'h0000_0BC0, 32'h0, '0, 1'b0, pat(8'hCB),
           1'b1, 32'h0000_07C0, merged, rd);
    check_counts("t4");

    // Test 5: reset while ALLOCATE has a response arriving
    @(negedge clk);
    mem_addr = 32'h0000_0040; mem_read = 1'b1; mem_byte_enable = 32'h0;
    @(posedge clk); #1;
    check_val("t5.alloc_read", pmem_read, 1'b1);
    check_val("t5.alloc_addr", pmem_addr, 32'h0000_0040);
    @(negedge clk);
    reset_n = 1'b0; pmem_rdata = pat(8'h77); pmem_resp = 1'b1;
    @(posedge clk); #1;
    mem_read = 1'b0; pmem_resp = 1'b0;
    exp_hits = 0; exp_misses = 0;
    check_val("t5.rst_pmem_read", pmem_read, 1'b0);
    check_val("t5.rst_pmem_write", pmem_write, 1'b0);
    check_counts("t5.rst");
    @(negedge clk); reset_n = 1'b1;
    read_miss("t5.invalid", 32'h0000_05A0, pat(8'h90));
    check_counts("t5.after_miss");
    @(negedge clk);
    mem_addr = 32'h0000_05A0; mem_read = 1'b1; hit_clear = 1'b1;
    #1;
    check_val("t5.clr_hit_resp", mem_resp, 1'b1);
    @(posedge clk); #1;
    mem_read = 1'b0; hit_clear = 1'b0;
    check_val("t5.hit_clear_wins", hit_count, 32'h0);
    check_val("t5.miss_kept", miss_count, 32'h1);
    @(negedge clk); miss_clear = 1'b1;
    @(posedge clk); #1; miss_clear = 1'b0;
    check_val("t5.miss_clear", miss_count, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
